// File: rtl/apb_rr_master.sv
// Two-requester APB master: round-robin grant, SETUP/ACCESS sequencing,
// wait-state counting with a bounded timeout that aborts with an error pulse.
module apb_rr_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              write0,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_last;
    logic               r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done0;
    logic               r_done1;
    logic               r_err0;
    logic               r_err1;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_psel;
    logic               r_penable;
    logic               r_pwrite;
    logic [ADDR_W-1:0]  r_paddr;
    logic [DATA_W-1:0]  r_pwdata;
    logic               w_gnt;

    // Round-robin pick: a tie goes to the requester not granted last time.
    always_comb begin
        w_gnt = 1'b0;
        if (req0 && req1) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = req1;
        end
    end

    // Transfer FSM with all bus and completion outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_gnt     <= 1'b0;
            r_cnt     <= {CNT_W{1'b0}};
            r_done0   <= 1'b0;
            r_done1   <= 1'b0;
            r_err0    <= 1'b0;
            r_err1    <= 1'b0;
            r_rdata   <= {DATA_W{1'b0}};
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= {ADDR_W{1'b0}};
            r_pwdata  <= {DATA_W{1'b0}};
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_penable <= 1'b0;
                    if (req0 || req1) begin
                        r_state  <= ST_SETUP;
                        r_gnt    <= w_gnt;
                        r_last   <= w_gnt;
                        r_pwrite <= w_gnt ? write1 : write0;
                        r_paddr  <= w_gnt ? addr1 : addr0;
                        r_pwdata <= w_gnt ? wdata1 : wdata0;
                        r_psel   <= 1'b1;
                        r_cnt    <= {CNT_W{1'b0}};
                    end else begin
                        r_psel <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_state   <= ST_ACCESS;
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (pready) begin
                        r_state   <= ST_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_done0   <= ~r_gnt;
                        r_done1   <= r_gnt;
                        if (!r_pwrite) begin
                            r_rdata <= prdata;
                        end else begin
                            r_rdata <= r_rdata;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                        // Slave never answered: abort and report an error.
                        r_state   <= ST_IDLE;
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_err0    <= ~r_gnt;
                        r_err1    <= r_gnt;
                        r_rdata   <= {DATA_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                end
            endcase
        end
    end

    assign done0   = r_done0;
    assign done1   = r_done1;
    assign err0    = r_err0;
    assign err1    = r_err1;
    assign rdata   = r_rdata;
    assign psel    = r_psel;
    assign penable = r_penable;
    assign pwrite  = r_pwrite;
    assign paddr   = r_paddr;
    assign pwdata  = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Scoreboard bench for apb_rr_master: stimulus queues expected completions,
// a negedge monitor pops and compares them as done/err pulses appear.
module tb_apb_rr_master;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       write0 = 1'b0, write1 = 1'b0;
    logic [7:0] addr0 = 8'h00, addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
    logic       done0, done1, err0, err1;
    logic [7:0] rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata;
    logic       pready = 1'b1;
    logic [7:0] prdata = 8'h00;

    apb_rr_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .write0(write0), .write1(write1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .err0(err0), .err1(err1),
        .rdata(rdata), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        int         is_err;
        logic [7:0] rd;
        int         edg;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   edge_cnt = 0;
    int   e0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int id, input int is_err, input logic [7:0] rd, input int edg);
        exp_t e;
        e.id = id; e.is_err = is_err; e.rd = rd; e.edg = edg;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Completion monitor: every done/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (done0 || done1 || err0 || err1)) begin
            chk("pulse_onehot", 32'(done0) + 32'(done1) + 32'(err0) + 32'(err1), 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {28'd0, done0, done1, err0, err1}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("cpl_id", 32'(done1 | err1), 32'(e.id));
                chk("cpl_err", 32'(err0 | err1), 32'(e.is_err));
                chk("cpl_rdata", 32'(rdata), 32'(e.rd));
                chk("cpl_edge", 32'(edge_cnt), 32'(e.edg));
            end
        end
    end

    initial begin
        step(); step();
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_pwrite", 32'(pwrite), 32'd0);
        chk("rst_paddr", 32'(paddr), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_pulses", {28'd0, done0, done1, err0, err1}, 32'd0);
        rst = 1'b1;
        step();

        // Single zero-wait write from requester 0.
        req0 = 1'b1; write0 = 1'b1; addr0 = 8'h02; wdata0 = 8'hFF; pready = 1'b1;
        e0 = edge_cnt + 1;
        push(0, 0, 8'h00, e0 + 2);
        step();
        chk("wr_setup_psel", 32'(psel), 32'd1);
        chk("wr_setup_penable", 32'(penable), 32'd0);
        chk("wr_pwrite", 32'(pwrite), 32'd1);
        chk("wr_paddr", 32'(paddr), 32'h02);
        chk("wr_pwdata", 32'(pwdata), 32'hFF);
        step();
        chk("wr_access", {30'd0, psel, penable}, 32'd3);
        step();
        req0 = 1'b0;
        chk("wr_done_psel", 32'(psel), 32'd0);
        step();

        // Read from requester 1 with two wait states.
        req1 = 1'b1; write1 = 1'b0; addr1 = 8'h02; prdata = 8'hA5; pready = 1'b0;
        e0 = edge_cnt + 1;
        push(1, 0, 8'hA5, e0 + 4);
        step(); step();
        chk("rd_access", {29'd0, psel, penable, pwrite}, 32'd6);
        step(); step();
        pready = 1'b1;
        step();
        req1 = 1'b0;
        step();

        // Requester 0 alone, three back-to-back writes.
        req0 = 1'b1; write0 = 1'b1; addr0 = 8'h10; wdata0 = 8'h33;
        e0 = edge_cnt + 1;
        push(0, 0, 8'hA5, e0 + 2);
        push(0, 0, 8'hA5, e0 + 5);
        push(0, 0, 8'hA5, e0 + 8);
        for (int k = 0; k <= 8; k++) begin
            step();
            if (k == 2) chk("b2b_gap_psel", 32'(psel), 32'd0);
            if (k == 3) chk("b2b_resetup", {30'd0, psel, penable}, 32'd2);
            if (k == 8) req0 = 1'b0;
        end
        step();

        // Contention: last grant was 0, so requester 1 goes first.
        req0 = 1'b1; write0 = 1'b0; addr0 = 8'h20;
        req1 = 1'b1; write1 = 1'b0; addr1 = 8'h21; prdata = 8'h3C;
        e0 = edge_cnt + 1;
        push(1, 0, 8'h3C, e0 + 2);
        push(0, 0, 8'h3C, e0 + 5);
        push(1, 0, 8'h3C, e0 + 8);
        push(0, 0, 8'h3C, e0 + 11);
        for (int k = 0; k <= 11; k++) begin
            step();
            if (k == 0) chk("rr_first_paddr", 32'(paddr), 32'h21);
            if (k == 3) chk("rr_second_paddr", 32'(paddr), 32'h20);
            if (k == 8) req1 = 1'b0;
            if (k == 11) req0 = 1'b0;
        end
        step();

        // Timeout: slave never ready.
        pready = 1'b0; req0 = 1'b1; write0 = 1'b0; addr0 = 8'h05;
        e0 = edge_cnt + 1;
        push(0, 1, 8'h00, e0 + 17);
        for (int k = 0; k <= 17; k++) begin
            step();
            if (k == 16) chk("to_still_access", {30'd0, psel, penable}, 32'd3);
            if (k == 17) begin
                req0 = 1'b0;
                chk("to_bus_drop", {30'd0, psel, penable}, 32'd0);
            end
        end
        step();

        // Reset in the middle of an ACCESS wait: silent abort.
        req1 = 1'b1; write1 = 1'b1; addr1 = 8'h07; wdata1 = 8'h77;
        for (int k = 0; k <= 3; k++) step();
        chk("mid_in_access", {30'd0, psel, penable}, 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_bus", {29'd0, psel, penable, pwrite}, 32'd0);
        chk("mid_rst_paddr", 32'(paddr), 32'd0);
        chk("mid_rst_pwdata", 32'(pwdata), 32'd0);
        req1 = 1'b0;
        step(); step();
        rst = 1'b1;
        pready = 1'b1;
        for (int k = 0; k < 4; k++) step();

        // After reset the pointer is back at 1, so requester 0 wins the tie.
        req0 = 1'b1; write0 = 1'b0; addr0 = 8'h30;
        req1 = 1'b1; write1 = 1'b0; addr1 = 8'h31; prdata = 8'h5A;
        e0 = edge_cnt + 1;
        push(0, 0, 8'h5A, e0 + 2);
        push(1, 0, 8'h5A, e0 + 5);
        for (int k = 0; k <= 5; k++) begin
            step();
            if (k == 0) chk("post_rst_paddr", 32'(paddr), 32'h30);
            if (k == 2) req0 = 1'b0;
            if (k == 5) req1 = 1'b0;
        end
        step(); step(); step();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_rr_master.md
# apb_rr_master

Two-requester APB master with round-robin arbitration, sequencing every access to the single 8-bit `APB_slave` register block. Each requester issues a read or write with a level request and receives a one-cycle completion pulse. The block owns the APB SETUP/ACCESS sequencing, wait-state handling and a bounded wait timeout. It sits between the internal requesters and the APB slave's bus port.

## Interface
- `ADDR_W`, 8, APB address width
- `DATA_W`, 8, APB data width
- `TIMEOUT`, 15, max ACCESS cycles waiting for `pready` before abort (≥1)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset; one clock; reset is asynchronous and active-low
- `req0`, `req1`  in  1  transfer request, level, held until matching done/err
- `write0`, `write1`  in  1  1 = write, 0 = read; stable while req high
- `addr0`, `addr1`  in  ADDR_W  transfer address; stable while req high
- `wdata0`, `wdata1`  in  DATA_W  write data; stable while req high
- `done0`, `done1`  out  1  one-cycle pulse: transfer finished OK
- `err0`, `err1`  out  1  one-cycle pulse: transfer aborted on timeout
- `rdata`  out  DATA_W  read data, valid in the done cycle of a read
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  ADDR_W  APB address
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  1  APB slave ready
- `prdata`  in  DATA_W  APB slave read data

## Operation
- FSM states: IDLE, SETUP, ACCESS. All outputs registered.
- IDLE: psel=0, penable=0. If any req high at the clock edge, arbitrate, latch winner's write/addr/wdata onto pwrite/paddr/pwdata, go SETUP.
- Arbitration: round-robin pointer `last` = last granted index. Single request wins directly; both high → grant the index ≠ `last`. Update `last` on grant.
- SETUP: psel=1, penable=0 for exactly one cycle → ACCESS.
- ACCESS: psel=1, penable=1; paddr/pwrite/pwdata held. Wait counter increments each ACCESS cycle with pready=0.
  - pready=1 at edge: → IDLE; pulse done of granted requester next cycle; on read, rdata ← prdata (captured at that edge); on write, rdata unchanged.
  - Counter reaches TIMEOUT with pready still 0: → IDLE; pulse err of granted requester; rdata ← 0; psel/penable drop.
- Completion cycle is an IDLE cycle; arbitration runs in it. A req still high during its own done/err cycle counts as a new request (back-to-back); the other requester wins if also pending.
- Counter width $clog2(TIMEOUT+1); cleared on entering SETUP; never wraps.
- Requests changing while not granted: ignored until next IDLE sample. Dropping req while granted does not cancel the transfer.
- done and err never both high; never high for both requesters at once.

## Timing
- Reset (async assert, sync deassert by user): state=IDLE, `last`=1 (req0 wins first tie), counter=0, psel=penable=pwrite=0, paddr=pwdata=rdata=0, done0/1=err0/1=0. Reset mid-transfer aborts silently: no done/err.
- Zero-wait transfer, req sampled at edge E0: SETUP cycle after E0, ACCESS after E1, pready seen at E2, done pulse after E2. Request-to-done = 3 cycles; minimum transfer period 3 cycles.
- Each pready=0 ACCESS cycle adds one cycle.
- Timeout: err pulse after TIMEOUT+1 ACCESS cycles' worth of edges, i.e. request-to-err = TIMEOUT+3 cycles.

## Test plan
- Reset: assert rst=0 mid-ACCESS → all outputs 0 immediately, no done/err after release; first access after release behaves normally.
- Single write: req0=1, write0=1, addr0=8'h02, wdata0=8'hFF, pready=1 → psel 1 cycle with penable=0, then psel=penable=1, paddr=8'h02, pwdata=8'hFF; done0 3 cycles after request.
- Single read with 2 wait states: req1=1, write1=0, addr1=8'h02, prdata=8'hA5, pready low 2 ACCESS cycles → done1 at cycle 5, rdata=8'hA5.
- Contention: req0 and req1 both held high from reset → grants 0,1,0,1…; done0/done1 alternate every 3 cycles; never both.
- Timeout: TIMEOUT=15, pready tied 0, req0 read → err0 pulse at cycle 18, rdata=0, psel=0 next cycle, done0 never pulses.
- Back-to-back: req0 held high alone for 3 transfers → done0 at cycles 3, 6, 9; psel low exactly one cycle between transfers.
